// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle for the PPC-to-Simulink register bank.
// Big-endian OPB bit numbering: index 0 is the most significant bit.
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of 32-bit OPB software registers: writable ones drive user logic,
// read-only ones sample user logic. Single clock, one-cycle acknowledge.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]              C_BASEADDR   = 32'h01080A00,
  parameter logic [31:0]              C_HIGHADDR   = 32'h01080AFF,
  parameter int                       C_OPB_AWIDTH = 32,
  parameter int                       C_OPB_DWIDTH = 32,
  parameter int                       C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0]    C_RO_MASK    = '0,
  parameter logic [C_NUM_REGS*32-1:0] C_RESET_VALS = '0,
  parameter                           C_FAMILY     = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave bus,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  input  logic [C_NUM_REGS*32-1:0]   user_data_in,
  output logic [C_NUM_REGS-1:0]      user_data_valid
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                  state, state_n;
  logic                    hit, capture, ack, commit;
  logic [31:0]             word;
  logic [C_NUM_REGS-1:0]   sel_next;
  logic [31:0]             rd_chain [C_NUM_REGS+1];

  logic                    rnw_p1;
  logic [3:0]              be_p1;
  logic [31:0]             wdata_p1;
  logic [31:0]             rdata_p1;
  logic [C_NUM_REGS-1:0]   sel_p1;

  // Bus parameters that are informational only at this data width.
  logic unused_ok;
  assign unused_ok = ^{bus.OPB_seqAddr, C_FAMILY, C_OPB_AWIDTH[0], C_OPB_DWIDTH[0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

  assign hit  = bus.OPB_select && (bus.OPB_ABus >= C_BASEADDR) && (bus.OPB_ABus <= C_HIGHADDR);
  assign word = (bus.OPB_ABus - C_BASEADDR) >> 2;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      IDLE: if (hit) begin
        state_n = ACK;
        capture = 1'b1;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Reset in the ACK cycle must kill both the handshake and the write.
  assign ack    = (state == ACK) && !OPB_Rst;
  assign commit = ack && !rnw_p1;

  assign rd_chain[0] = '0;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
    logic [31:0] src;
    assign sel_next[g]   = (word == 32'(g));
    assign src           = C_RO_MASK[g] ? user_data_in[32*g +: 32] : user_data_out[32*g +: 32];
    assign rd_chain[g+1] = rd_chain[g] | (sel_next[g] ? src : 32'h0);

    if (C_RO_MASK[g]) begin : g_ro
      assign user_data_out[32*g +: 32] = '0;
      assign user_data_valid[g]        = 1'b0;
    end else begin : g_rw
      logic [31:0] reg_q;
      logic        vld_q;
      always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
          reg_q <= C_RESET_VALS[32*g +: 32];
          vld_q <= 1'b0;
        end else begin
          vld_q <= 1'b0;
          if (commit && sel_p1[g]) begin
            reg_q <= merge_bytes(reg_q, wdata_p1, be_p1);
            vld_q <= |be_p1;
          end
        end
      end
      assign user_data_out[32*g +: 32] = reg_q;
      assign user_data_valid[g]        = vld_q;
    end
  end

  // Stage p1: request captured on the IDLE->ACK edge
  always_ff @(posedge OPB_Clk) begin
    if (capture) begin
      rnw_p1   <= bus.OPB_RNW;
      be_p1    <= bus.OPB_BE;
      wdata_p1 <= bus.OPB_DBus;
      sel_p1   <= sel_next;
      rdata_p1 <= bus.OPB_RNW ? rd_chain[C_NUM_REGS] : 32'h0;
    end
  end

  assign bus.Sl_xferAck = ack;
  assign bus.Sl_DBus    = ack ? rdata_p1 : 32'h0;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench: directed scenarios plus random traffic against a
// register-array model of the bank.
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h01080A00;
  localparam logic [31:0] HIGH = 32'h01080AFF;
  localparam logic [127:0] RST_VALS = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] udo;
  logic [127:0] udi = '0;
  logic [3:0]   udv;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [4];

  opb_register_bank_ppc2simulink_if bus ();

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS  (4),
    .C_RO_MASK   (4'b1000),
    .C_RESET_VALS(RST_VALS)
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .bus            (bus.slave),
    .user_data_out  (udo),
    .user_data_in   (udi),
    .user_data_valid(udv)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_reg[0] = 32'h0; m_reg[1] = 32'hDEADBEEF; m_reg[2] = 32'h0; m_reg[3] = 32'h0;
  endfunction

  function automatic logic [127:0] model_out();
    return {32'h0, m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  function automatic logic [31:0] model_read(input longint idx);
    if (idx >= 4) return 32'h0;
    if (idx == 3) return udi[127:96];
    return m_reg[idx];
  endfunction

  // Returns the strobe pattern the write should produce.
  function automatic logic [3:0] model_write(input longint idx, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] mask;
    if (idx >= 3) return 4'b0000;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    m_reg[idx] = (m_reg[idx] & ~mask) | (d & mask);
    return (be != 4'b0) ? (4'b0001 << idx) : 4'b0000;
  endfunction

  task automatic bus_idle();
    bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0; bus.OPB_ABus = '0;
    bus.OPB_BE = '0; bus.OPB_DBus = '0; bus.OPB_seqAddr = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                      input logic [31:0] data, input string name);
    logic        in_win;
    longint      idx;
    logic [31:0] exp_rd;
    logic [3:0]  exp_vld;
    in_win  = (addr >= BASE) && (addr <= HIGH);
    idx     = longint'((addr - BASE) >> 2);
    exp_rd  = (in_win && rnw) ? model_read(idx) : 32'h0;
    exp_vld = 4'b0000;
    @(posedge clk); #1;
    bus.OPB_select = 1'b1; bus.OPB_RNW = rnw; bus.OPB_ABus = addr;
    bus.OPB_BE = be; bus.OPB_DBus = data;
    @(negedge clk);
    checks++;
    if (bus.Sl_xferAck !== 1'b0) begin
      errors++; $display("FAIL %s early_ack: got %b expected 0", name, bus.Sl_xferAck);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.Sl_xferAck !== in_win) begin
      errors++; $display("FAIL %s ack: got %b expected %b", name, bus.Sl_xferAck, in_win);
    end
    checks++;
    if (bus.Sl_DBus !== exp_rd) begin
      errors++; $display("FAIL %s rdata: got %h expected %h", name, bus.Sl_DBus, exp_rd);
    end
    bus_idle();
    if (in_win && !rnw) exp_vld = model_write(idx, be, data);
    @(posedge clk); #1;
    checks++;
    if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin
      errors++; $display("FAIL %s post_ack: got ack=%b dbus=%h expected 0/0", name, bus.Sl_xferAck, bus.Sl_DBus);
    end
    checks++;
    if (udv !== exp_vld) begin
      errors++; $display("FAIL %s valid: got %b expected %b", name, udv, exp_vld);
    end
    checks++;
    if (udo !== model_out()) begin
      errors++; $display("FAIL %s regs: got %h expected %h", name, udo, model_out());
    end
    @(posedge clk); #1;
    checks++;
    if (udv !== 4'b0000) begin
      errors++; $display("FAIL %s valid_drop: got %b expected 0000", name, udv);
    end
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.Sl_xferAck !== 1'b0 || udv !== 4'b0000 || bus.Sl_DBus !== 32'h0) begin
        errors++; $display("FAIL reset_outputs: got ack=%b valid=%b dbus=%h expected 0", bus.Sl_xferAck, udv, bus.Sl_DBus);
      end
    end
    rst = 1'b0;
    model_reset();
    checks++;
    if (udo !== {96'h0, 32'h0} + {64'h0, 32'hDEADBEEF, 32'h0}) begin
      errors++; $display("FAIL reset_values: got %h expected reg1=DEADBEEF", udo);
    end
  endtask

  task automatic test_write_readback();
    xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h12345678, "wr_reg1");
    checks++;
    if (udo[63:32] !== 32'h12345678) begin
      errors++; $display("FAIL wr_reg1_value: got %h expected 12345678", udo[63:32]);
    end
    xfer(BASE + 32'h4, 1'b1, 4'b0000, 32'h0, "rd_reg1");
  endtask

  task automatic test_partial_write();
    xfer(BASE, 1'b0, 4'b1111, 32'h0, "clr_reg0");
    xfer(BASE, 1'b0, 4'b0101, 32'hAABBCCDD, "partial_be0101");
    checks++;
    if (udo[31:0] !== 32'h00BB00DD) begin
      errors++; $display("FAIL partial_value: got %h expected 00BB00DD", udo[31:0]);
    end
    xfer(BASE, 1'b0, 4'b0000, 32'h11223344, "partial_be0000");
    xfer(BASE + 32'h1, 1'b1, 4'b0000, 32'h0, "rd_reg0_lowbits");
  endtask

  task automatic test_read_only();
    udi = {32'hCAFEF00D, 32'h01010101, 32'h02020202, 32'h03030303};
    xfer(BASE + 32'hC, 1'b1, 4'b1111, 32'h0, "ro_read");
    xfer(BASE + 32'hC, 1'b0, 4'b1111, 32'hFFFFFFFF, "ro_write");
    xfer(BASE + 32'hC, 1'b1, 4'b0000, 32'h0, "ro_reread");
    checks++;
    if (udo[127:96] !== 32'h0) begin
      errors++; $display("FAIL ro_out_zero: got %h expected 00000000", udo[127:96]);
    end
  endtask

  task automatic test_decode();
    xfer(32'h01080B00, 1'b1, 4'b1111, 32'h0, "out_of_window_rd");
    xfer(32'h01080B00, 1'b0, 4'b1111, 32'h55555555, "out_of_window_wr");
    xfer(BASE - 32'h4, 1'b1, 4'b1111, 32'h0, "below_window_rd");
    xfer(BASE + 32'd40, 1'b1, 4'b1111, 32'h0, "idx10_rd");
    xfer(BASE + 32'd40, 1'b0, 4'b1111, 32'h77777777, "idx10_wr");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    logic [3:0]  exp_vld;
    d[0] = 32'hA0A0A0A0; d[1] = 32'hB1B1B1B1; d[2] = 32'hC2C2C2C2;
    @(posedge clk); #1;
    bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b0; bus.OPB_BE = 4'b1111;
    bus.OPB_ABus = BASE; bus.OPB_DBus = d[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.Sl_xferAck !== 1'b1 || udv !== 4'b0000) begin
        errors++; $display("FAIL b2b_ack%0d: got ack=%b valid=%b expected 1/0000", k, bus.Sl_xferAck, udv);
      end
      exp_vld = model_write(k, 4'b1111, d[k]);
      if (k < 2) begin
        bus.OPB_ABus = BASE + 32'(4 * (k + 1));
        bus.OPB_DBus = d[k+1];
      end else begin
        bus_idle();
      end
      @(posedge clk); #1;
      checks++;
      if (bus.Sl_xferAck !== 1'b0 || udv !== exp_vld) begin
        errors++; $display("FAIL b2b_gap%0d: got ack=%b valid=%b expected 0/%b", k, bus.Sl_xferAck, udv, exp_vld);
      end
      checks++;
      if (udo !== model_out()) begin
        errors++; $display("FAIL b2b_regs%0d: got %h expected %h", k, udo, model_out());
      end
    end
  endtask

  task automatic test_reset_in_ack();
    @(posedge clk); #1;
    bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b0; bus.OPB_BE = 4'b1111;
    bus.OPB_ABus = BASE + 32'h4; bus.OPB_DBus = 32'h5A5A5A5A;
    @(posedge clk); #1;
    checks++;
    if (bus.Sl_xferAck !== 1'b1) begin
      errors++; $display("FAIL rst_ack_pre: got %b expected 1", bus.Sl_xferAck);
    end
    rst = 1'b1;
    bus_idle();
    #1;
    checks++;
    if (bus.Sl_xferAck !== 1'b0) begin
      errors++; $display("FAIL rst_ack_abort: got %b expected 0", bus.Sl_xferAck);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (udo !== model_out() || udv !== 4'b0000) begin
      errors++; $display("FAIL rst_ack_regs: got %h valid=%b expected %h", udo, udv, model_out());
    end
    @(posedge clk); #1;
    checks++;
    if (bus.Sl_xferAck !== 1'b0 || udv !== 4'b0000 || udo[63:32] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rst_ack_after: got ack=%b valid=%b reg1=%h expected 0/0000/DEADBEEF", bus.Sl_xferAck, udv, udo[63:32]);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      udi = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0)
        addr = ($urandom_range(0, 1) == 1) ? HIGH + 32'($urandom_range(1, 64)) : BASE - 32'($urandom_range(1, 64));
      else
        addr = BASE + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
      xfer(addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, "random");
    end
  endtask

  initial begin
    bus_idle();
    model_reset();
    test_reset();
    test_write_readback();
    test_partial_write();
    test_read_only();
    test_decode();
    test_back_to_back();
    test_reset_in_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
